seq_timer_ctrl: RTL and testbench
=================================

# seq_timer_ctrl

Sequencing controller for the serial-command timer path. It watches the `data` line for a start pattern and then shifts in a delay field. It then runs a prescaled countdown of (delay+1)×TICKS cycles, raises `done`, and holds until the user acknowledges. It sits after the start-pattern detector stage and drives the shift-enable, count-enable and status outputs of the timer datapath.

## Interface
Parameters:
- `PATTERN`, default 4'b1101: start pattern, MSB received first.
- `PAT_LEN`, default 4: pattern length in bits (≥2).
- `DLY_W`, default 4: delay field width in bits.
- `TICKS`, default 1000: clock cycles per delay unit (≥2).

Ports:
- `clk`  in  1: clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `data`  in  1: serial input; pattern and delay bits, one per cycle.
- `ack`  in  1: user acknowledge; honoured only in DONE.
- `shift_ena`  out  1: high while the delay field is being captured.
- `counting`  out  1: high during the countdown.
- `done`  out  1: high from countdown expiry until `ack`.
- `count`  out  DLY_W: remaining delay units during COUNT; 0 in all other states.

## Operation
- States: IDLE, SHIFT, COUNT, DONE. Reset → IDLE.
- Registers: history `hist[PAT_LEN-1:0]`, delay register `dly[DLY_W-1:0]`, bit counter, tick counter.
- IDLE
  - Each edge: `hist <= {hist[PAT_LEN-2:0], data}`.
  - If `{hist[PAT_LEN-2:0], data} == PATTERN`, go to SHIFT and clear the bit counter.
  - Overlapping matches are detected (e.g. 1101 inside 1111101).
- SHIFT
  - Each edge: `dly <= {dly[DLY_W-2:0], data}` (MSB first); bit counter increments.
  - On the DLY_W-th sample, go to COUNT and clear the tick counter.
- COUNT
  - The tick counter runs 0..TICKS-1.
  - At TICKS-1 with `dly == 0`: go to DONE.
  - At TICKS-1 with `dly != 0`: decrement `dly` and wrap the tick counter to 0.
  - Total COUNT dwell is exactly (dly_initial+1)×TICKS cycles.
- DONE
  - Stay until `ack == 1` is sampled, then go to IDLE.
  - On return to IDLE, clear `hist`, so a complete new pattern is required. Pattern bits present during DONE are not retained.
- `ack` in IDLE, SHIFT or COUNT is ignored.
- `data` in COUNT and DONE is ignored.
- No arithmetic wrap: `dly` is never decremented below 0.

## Timing
- Outputs are registered-state decodes (Moore): `shift_ena = (state==SHIFT)`, `counting = (state==COUNT)`, `done = (state==DONE)`. `count = dly` in COUNT, else 0.
- Reset values: `shift_ena`=0, `counting`=0, `done`=0, `count`=0, `hist`=0, `dly`=0, all counters 0.
- Latencies:
  - The last pattern bit is sampled at edge k; `shift_ena` is high for cycles k+1..k+DLY_W.
  - `counting` is high from cycle k+DLY_W+1 for (D+1)×TICKS cycles.
  - `done` rises on the next cycle.
- `ack` sampled at edge m → `done` low from cycle m+1. In that cycle IDLE is already sampling `data`, with history empty.
- A single-cycle `ack` pulse is sufficient. An `ack` held high across DONE entry exits DONE after one cycle.
- `reset` in any state returns to IDLE at the next edge and overrides everything. Reset mid-SHIFT or mid-COUNT discards the delay.
- Tick counter width is `$clog2(TICKS)`. Bit counter width is `$clog2(DLY_W+1)`.

## Structure
- Package `seq_timer_pkg`: state enum (IDLE, SHIFT, COUNT, DONE) and default `PATTERN`/`PAT_LEN` constants.
- Sub-module `tick_prescaler`:
  - Parameter TICKS; inputs `clr`, `en`; output `tc`, a terminal-count pulse when at TICKS-1 and enabled.
  - Instantiated once; `clr` is asserted on SHIFT→COUNT.
- Top: FSM, history register, delay shift/decrement register, bit counter.

## Test plan
(Run with TICKS=4 unless noted.)
- Reset, then data 1,1,0,1 followed by delay bits 0,1,0,1 → `shift_ena` high 4 cycles; `counting` 24 cycles; `count` = 5,4,3,2,1,0 for 4 cycles each; then `done`=1. `ack` pulse → `done`=0 on the next cycle.
- Data 1,1,1,1,1,0,1 followed by delay 0,0,0,0 → detection of the overlapping pattern; `counting` exactly 4 cycles; `count`=0 throughout.
- `ack` held high during SHIFT and COUNT → no effect; `done` lasts exactly 1 cycle. Then data 1,1,0,1 immediately after → a new SHIFT begins.
- `reset` asserted mid-COUNT (count=3) → next cycle all outputs 0, IDLE. Pattern 1101 plus delay 0001 → `counting` 8 cycles.
- In DONE, drive 1,1,0,1 without `ack` → no SHIFT. After `ack`, a stale partial pattern is not matched; a full fresh 1101 is required.
- TICKS=1000, delay 1111 → `counting` exactly 16000 cycles.

Source files
------------

// File: rtl/seq_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_timer_pkg                                                      |
// | Shared state encoding and default start pattern for the timer.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package seq_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         c_PAT_LEN = 4;
  localparam logic [3:0] c_PATTERN = 4'b1101;

endpackage
`default_nettype wire

// File: rtl/seq_timer_ctrl_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_prescaler                                                     |
// | Free counter 0..TICKS-1; tc pulses at TICKS-1 while enabled.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tick_prescaler #(
  parameter int TICKS = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int              c_CW   = $clog2(TICKS);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TICKS - 1);

  logic [c_CW-1:0] r_cnt;

  assign tc = en && (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (tc) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_timer_ctrl                                                     |
// | Start-pattern detect, delay capture, prescaled countdown, done/ack.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seq_timer_ctrl
  import seq_timer_pkg::*;
#(
  parameter int                 PAT_LEN = c_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(c_PATTERN),
  parameter int                 DLY_W   = 4,
  parameter int                 TICKS   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             ack,
  output logic             shift_ena,
  output logic             counting,
  output logic             done,
  output logic [DLY_W-1:0] count
);

  localparam int              c_BW       = $clog2(DLY_W + 1);
  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DLY_W - 1);

  state_t             r_state;
  state_t             w_state_next;
  // The oldest history bit only ever feeds the match window, so it is not stored.
  logic [PAT_LEN-2:0] r_hist;
  logic [PAT_LEN-1:0] w_window;
  logic [DLY_W-1:0]   r_dly;
  logic [c_BW-1:0]    r_bits;
  logic               w_match;
  logic               w_last_bit;
  logic               w_pre_clr;
  logic               w_pre_en;
  logic               w_tc;

  assign w_window   = {r_hist, data};
  assign w_match    = (w_window == PATTERN);
  assign w_last_bit = (r_bits == c_LAST_BIT);
  assign w_pre_en   = (r_state == COUNT);

  tick_prescaler #(
    .TICKS (TICKS)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_pre_clr),
    .en    (w_pre_en),
    .tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pre_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_match) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_last_bit) begin
          w_state_next = COUNT;
          w_pre_clr    = 1'b1;
        end
      end
      COUNT: begin
        if (w_tc && (r_dly == '0)) w_state_next = DONE;
      end
      DONE: begin
        if (ack) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Delay register doubles as the remaining-units counter during COUNT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_dly  <= '0;
      r_bits <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hist <= w_window[PAT_LEN-2:0];
          r_bits <= '0;
        end
        SHIFT: begin
          r_dly  <= {r_dly[DLY_W-2:0], data};
          r_bits <= r_bits + c_BW'(1);
        end
        COUNT: begin
          if (w_tc && (r_dly != '0)) r_dly <= r_dly - DLY_W'(1);
        end
        DONE: begin
          if (ack) r_hist <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign shift_ena = (r_state == SHIFT);
  assign counting  = (r_state == COUNT);
  assign done      = (r_state == DONE);
  assign count     = counting ? r_dly : '0;

endmodule
`default_nettype wire

// File: tb/tb_seq_timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_timer_ctrl                                                  |
// | Scoreboard bench: expected output runs queued, monitors compare.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_seq_timer_ctrl;

  localparam int c_TICKS   = 4;
  localparam int c_TICKS_L = 1000;
  localparam int EV_SHIFT  = 0;
  localparam int EV_COUNT  = 1;
  localparam int EV_DONE   = 2;

  typedef struct {
    int kind;
    int len;
    int d;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data = 1'b0;
  logic       ack = 1'b0;
  logic       data2 = 1'b0;
  logic       ack2 = 1'b0;
  logic       shift_ena, counting, done;
  logic [3:0] count;
  logic       shift_ena2, counting2, done2;
  logic [3:0] count2;

  ev_t exp_q[$];
  ev_t exp_q2[$];
  int  errors = 0;
  int  checks = 0;

  seq_timer_ctrl #(
    .PAT_LEN (4), .PATTERN (4'b1101), .DLY_W (4), .TICKS (c_TICKS)
  ) u_dut (
    .clk (clk), .reset (reset), .data (data), .ack (ack),
    .shift_ena (shift_ena), .counting (counting), .done (done), .count (count)
  );

  seq_timer_ctrl #(
    .PAT_LEN (4), .PATTERN (4'b1101), .DLY_W (4), .TICKS (c_TICKS_L)
  ) u_long (
    .clk (clk), .reset (reset), .data (data2), .ack (ack2),
    .shift_ena (shift_ena2), .counting (counting2), .done (done2), .count (count2)
  );

  initial forever #5 clk = ~clk;

  function automatic ev_t mk(input int kind, input int len, input int d);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    e.d    = d;
    return e;
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      EV_SHIFT: return "shift_ena";
      EV_COUNT: return "counting";
      default:  return "done";
    endcase
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input bit sel, input int kind, input int len, input bit bad);
    ev_t e;
    int  qs;
    qs = sel ? exp_q2.size() : exp_q.size();
    checks++;
    if (qs == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got run of %0d cycles, expected no run", kname(kind), len);
      return;
    end
    if (sel) e = exp_q2.pop_front();
    else     e = exp_q.pop_front();
    if (e.kind != kind || e.len != len) begin
      errors++;
      $display("FAIL run_%s: got %s high %0d cycles, expected %s high %0d cycles",
               kname(e.kind), kname(kind), len, kname(e.kind), e.len);
    end
    if (kind == EV_COUNT) begin
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL count_seq: got wrong count value, expected %0d stepping down to 0", e.d);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (sel) data2 = bits[i];
      else     data  = bits[i];
      tick();
    end
    if (sel) data2 = 1'b0;
    else     data  = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int max, input string name);
    int n;
    n = 0;
    while (((sel ? done2 : done) == 1'b0) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if ((sel ? done2 : done) == 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles, expected done=1", name, max);
    end
  endtask

  // Monitor for the TICKS=4 instance: measures each high run of the status outputs.
  initial begin : mon_main
    int sh, ct, dn, exp_cnt;
    bit bad;
    sh = 0; ct = 0; dn = 0; bad = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (shift_ena) sh++;
      else if (sh > 0) begin
        pop_check(1'b0, EV_SHIFT, sh, 1'b0);
        sh = 0;
      end
      if (counting) begin
        exp_cnt = (exp_q.size() > 0 && exp_q[0].kind == EV_COUNT) ? exp_q[0].d - ct / c_TICKS : -1;
        if (int'(count) != exp_cnt) bad = 1'b1;
        ct++;
      end else begin
        check_val("count_zero_outside_count", int'(count), 0);
        if (ct > 0) begin
          pop_check(1'b0, EV_COUNT, ct, bad);
          ct  = 0;
          bad = 1'b0;
        end
      end
      if (done) dn++;
      else if (dn > 0) begin
        pop_check(1'b0, EV_DONE, dn, 1'b0);
        dn = 0;
      end
    end
  end

  // Monitor for the TICKS=1000 instance: countdown length and done run.
  initial begin : mon_long
    int ct, dn, exp_cnt;
    bit bad;
    ct = 0; dn = 0; bad = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (counting2) begin
        exp_cnt = (exp_q2.size() > 0 && exp_q2[0].kind == EV_COUNT) ? exp_q2[0].d - ct / c_TICKS_L : -1;
        if (int'(count2) != exp_cnt) bad = 1'b1;
        ct++;
      end else if (ct > 0) begin
        pop_check(1'b1, EV_COUNT, ct, bad);
        ct  = 0;
        bad = 1'b0;
      end
      if (done2) dn++;
      else if (dn > 0) begin
        pop_check(1'b1, EV_DONE, dn, 1'b0);
        dn = 0;
      end
    end
  end

  initial begin : stim
    repeat (2) tick();
    check_val("rst_shift_ena", int'(shift_ena), 0);
    check_val("rst_counting", int'(counting), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_count", int'(count), 0);
    reset = 1'b0;
    tick();

    // Pattern 1101, delay 5: ack pulse two cycles into DONE
    exp_q.push_back(mk(EV_SHIFT, 4, 0));
    exp_q.push_back(mk(EV_COUNT, 24, 5));
    exp_q.push_back(mk(EV_DONE, 3, 0));
    send(1'b0, 16'b1101_0101, 8);
    wait_done(1'b0, 100, "t1");
    repeat (2) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("done_after_ack", int'(done), 0);

    // Overlapping pattern in 1111101, delay 0
    exp_q.push_back(mk(EV_SHIFT, 4, 0));
    exp_q.push_back(mk(EV_COUNT, 4, 0));
    exp_q.push_back(mk(EV_DONE, 1, 0));
    send(1'b0, 16'b1111101_0000, 11);
    wait_done(1'b0, 100, "t2");
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // ack held through SHIFT/COUNT, then a new pattern right after DONE exits
    exp_q.push_back(mk(EV_SHIFT, 4, 0));
    exp_q.push_back(mk(EV_COUNT, 12, 2));
    exp_q.push_back(mk(EV_DONE, 1, 0));
    exp_q.push_back(mk(EV_SHIFT, 4, 0));
    exp_q.push_back(mk(EV_COUNT, 2, 3));
    ack = 1'b1;
    send(1'b0, 16'b1101_0010, 8);
    wait_done(1'b0, 100, "t3");
    tick();
    ack = 1'b0;
    send(1'b0, 16'b1101_0011, 8);

    // Reset in the second COUNT cycle
    check_val("count_at_abort", int'(count), 3);
    tick();
    reset = 1'b1;
    tick();
    check_val("abort_shift_ena", int'(shift_ena), 0);
    check_val("abort_counting", int'(counting), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_count", int'(count), 0);
    reset = 1'b0;
    exp_q.push_back(mk(EV_SHIFT, 4, 0));
    exp_q.push_back(mk(EV_COUNT, 8, 1));
    exp_q.push_back(mk(EV_DONE, 1, 0));
    send(1'b0, 16'b1101_0001, 8);
    wait_done(1'b0, 100, "t4");
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Pattern bits during DONE are ignored; stale history must not match after ack
    exp_q.push_back(mk(EV_SHIFT, 4, 0));
    exp_q.push_back(mk(EV_COUNT, 4, 0));
    exp_q.push_back(mk(EV_DONE, 8, 0));
    exp_q.push_back(mk(EV_SHIFT, 4, 0));
    exp_q.push_back(mk(EV_COUNT, 4, 0));
    exp_q.push_back(mk(EV_DONE, 1, 0));
    send(1'b0, 16'b1101_0000, 8);
    wait_done(1'b0, 100, "t5");
    send(1'b0, 16'b1101_110, 7);
    check_val("done_held_no_ack", int'(done), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    send(1'b0, 16'b101_1101_0000, 11);
    wait_done(1'b0, 100, "t6");
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // TICKS=1000, delay 15
    exp_q2.push_back(mk(EV_COUNT, 16000, 15));
    exp_q2.push_back(mk(EV_DONE, 1, 0));
    send(1'b1, 16'b1101_1111, 8);
    wait_done(1'b1, 17000, "long");
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;

    repeat (5) tick();
    check_val("pending_runs_main", exp_q.size(), 0);
    check_val("pending_runs_long", exp_q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
